fir_tdm_sequencer: RTL and testbench

FIR_TDM_SEQUENCER -- requirements
Module: fir_tdm_sequencer

---
 rtl/fir_seq_pkg.sv | 10 +
 rtl/fir_tdm_sequencer_if.sv | 24 ++
 rtl/sat_mac_unit.sv | 22 ++
 rtl/fir_tdm_sequencer.sv | 90 +++++++++
 tb/tb_fir_tdm_sequencer.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_seq_pkg.sv
// fir_seq_pkg: shared widths, saturation limits and enums for the TDM filter sequencer
package fir_seq_pkg;
    localparam int DATA_W = 16;
    localparam int COEF_W = 18;
    localparam int FRAC = COEF_W - 1;
    localparam logic signed [COEF_W-1:0] SAT_MAX = 18'sh1ffff;
    localparam logic signed [COEF_W-1:0] SAT_MIN = 18'sh20000;
    typedef enum logic [2:0] {IDLE, MAC_B0, MAC_B1, MAC_A1, OUT} state_e;
    typedef enum logic [1:0] {B0 = 2'd0, B1 = 2'd1, A1 = 2'd2} coef_addr_e;
endpackage

// File: rtl/fir_tdm_sequencer_if.sv
// fir_tdm_sequencer_if: sample input/output handshakes and coefficient write port
interface fir_tdm_sequencer_if #(parameter int NUM_CH = 4);
    import fir_seq_pkg::*;
    localparam int CH_W = $clog2(NUM_CH);
    logic [DATA_W-1:0] data_i;
    logic [CH_W-1:0]   ch_i;
    logic              valid_i;
    logic              ready_o;
    logic [DATA_W-1:0] data_o;
    logic [CH_W-1:0]   ch_o;
    logic              valid_o;
    logic              ready_i;
    logic              coef_we_i;
    logic [1:0]        coef_addr_i;
    logic [COEF_W-1:0] coef_data_i;
    modport slave (
        input  data_i, ch_i, valid_i, ready_i, coef_we_i, coef_addr_i, coef_data_i,
        output ready_o, data_o, ch_o, valid_o
    );
    modport master (
        output data_i, ch_i, valid_i, ready_i, coef_we_i, coef_addr_i, coef_data_i,
        input  ready_o, data_o, ch_o, valid_o
    );
endinterface

// File: rtl/sat_mac_unit.sv
// sat_mac_unit: one combinational acc + (coef*op >>> 17) step saturated to Q1.17
// FIR_SEQ_ROUND_EN adds half an LSB to the product before the shift
module sat_mac_unit import fir_seq_pkg::*; (
    input  logic signed [COEF_W-1:0] i_acc,
    input  logic signed [COEF_W-1:0] i_coef,
    input  logic signed [COEF_W-1:0] i_op,
    input  logic                     i_sub,
    output logic signed [COEF_W-1:0] o_acc
);
    localparam int PW = 2 * COEF_W + 1;
    logic signed [PW-1:0] w_op, w_prod, w_sum;
    always_comb begin
        w_op = i_sub ? -PW'(i_op) : PW'(i_op);
`ifdef FIR_SEQ_ROUND_EN
        w_prod = PW'(i_coef) * w_op + PW'(1 << (FRAC - 1));
`else
        w_prod = PW'(i_coef) * w_op;
`endif
        w_sum = (w_prod >>> FRAC) + PW'(i_acc);
        o_acc = w_sum > PW'(SAT_MAX) ? SAT_MAX : w_sum < PW'(SAT_MIN) ? SAT_MIN : w_sum[COEF_W-1:0];
    end
endmodule

// File: rtl/fir_tdm_sequencer.sv
// fir_tdm_sequencer: per-channel y = b0*x + b1*x[n-1] - a1*y[n-1] over one shared saturating MAC
// FIR_SEQ_ROUND_EN selects round-half-up on products and output; default is truncation
module fir_tdm_sequencer import fir_seq_pkg::*; #(
    parameter int NUM_CH = 4,
    parameter int inout_width = DATA_W,
    parameter int internal_width = COEF_W
) (
    input logic clk_i,
    input logic reset_i,
    fir_tdm_sequencer_if.slave bus
);
    localparam int CH_W = $clog2(NUM_CH);
    localparam int PAD_W = internal_width - inout_width;
    typedef logic signed [internal_width-1:0] word_t;
    state_e r_state, w_next;
    word_t r_acc, r_x, r_b0, r_b1, r_a1, r_sb0, r_sb1, r_sa1;
    word_t r_xh [NUM_CH];
    word_t r_yh [NUM_CH];
    logic [CH_W-1:0] r_ch;
    word_t w_coef, w_op, w_seed, w_mac;
    logic w_accept;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.valid_i ? MAC_B0 : IDLE;
            MAC_B0:  w_next = MAC_B1;
            MAC_B1:  w_next = MAC_A1;
            MAC_A1:  w_next = OUT;
            OUT:     w_next = bus.ready_i ? IDLE : OUT;
            default: w_next = IDLE;
        endcase
        bus.ready_o = r_state == IDLE;
        bus.valid_o = r_state == OUT;
        w_accept = r_state == IDLE && bus.valid_i;
        w_coef = r_state == MAC_B0 ? r_b0 : r_state == MAC_B1 ? r_b1 : r_a1;
        w_op = r_state == MAC_B0 ? r_x : r_state == MAC_B1 ? r_xh[r_ch] : r_yh[r_ch];
        w_seed = r_state == MAC_B0 ? '0 : r_acc;
    end

    sat_mac_unit u_mac (
        .i_acc  (w_seed),
        .i_coef (w_coef),
        .i_op   (w_op),
        .i_sub  (r_state == MAC_A1),
        .o_acc  (w_mac)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_acc <= '0;
            r_x <= '0;
            r_ch <= '0;
            {r_b0, r_sb0} <= {SAT_MAX, SAT_MAX};
            {r_b1, r_sb1} <= {SAT_MIN, SAT_MIN};
            {r_a1, r_sa1} <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_xh[i] <= '0;
                r_yh[i] <= '0;
            end
        end else begin
            r_state <= w_next;
            // commit happens before the shadow write of the same cycle lands
            if (r_state == IDLE) {r_b0, r_b1, r_a1} <= {r_sb0, r_sb1, r_sa1};
            if (bus.coef_we_i && bus.coef_addr_i == B0) r_sb0 <= bus.coef_data_i;
            if (bus.coef_we_i && bus.coef_addr_i == B1) r_sb1 <= bus.coef_data_i;
            if (bus.coef_we_i && bus.coef_addr_i == A1) r_sa1 <= bus.coef_data_i;
            if (w_accept) begin
                r_x <= {bus.data_i, PAD_W'(0)};
                r_ch <= bus.ch_i;
            end
            if (r_state inside {MAC_B0, MAC_B1, MAC_A1}) r_acc <= w_mac;
            if (r_state == MAC_A1) begin
                r_xh[r_ch] <= r_x;
                r_yh[r_ch] <= w_mac;
            end
        end
    end

`ifdef FIR_SEQ_ROUND_EN
    localparam int RW = internal_width + 1;
    logic signed [RW-1:0] w_rnd;
    assign w_rnd = ($signed({r_acc[internal_width-1], r_acc}) + RW'(2)) >>> PAD_W;
    assign bus.data_o = w_rnd > RW'((1 << (inout_width - 1)) - 1) ? {1'b0, {(inout_width-1){1'b1}}} : w_rnd[inout_width-1:0];
`else
    assign bus.data_o = r_acc[internal_width-1:PAD_W];
`endif
    assign bus.ch_o = r_ch;
endmodule

// File: tb/tb_fir_tdm_sequencer.sv
// tb_fir_tdm_sequencer: vector table, corner-case sequences and randomized run against an arithmetic model
module tb_fir_tdm_sequencer;
    logic clk = 0;
    logic rst = 1;
    int n_checks = 0;
    int n_fail = 0;

    fir_tdm_sequencer_if #(.NUM_CH(4)) bus ();
    fir_tdm_sequencer #(.NUM_CH(4)) dut (.clk_i(clk), .reset_i(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        bit rst;
        bit wr;
        int b0;
        int b1;
        int a1;
        int ch;
        int x;
        int exp_d;
    } vec_t;
    vec_t vecs [9];

    int m_b0, m_b1, m_a1;
    int m_xh [4];
    int m_yh [4];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic wcoef(input int addr, input int val);
        bus.coef_we_i = 1;
        bus.coef_addr_i = 2'(addr);
        bus.coef_data_i = 18'(val);
        tick();
        bus.coef_we_i = 0;
    endtask

    task automatic set_lin();
        wcoef(0, 65536);
        wcoef(1, 65536);
        wcoef(2, 0);
    endtask

    task automatic send(input int ch, input int x, input int stall, output int d, output int c, output int lat);
        int g = 0;
        bus.ch_i = 2'(ch);
        bus.data_i = 16'(x);
        bus.valid_i = 1;
        bus.ready_i = (stall == 0);
        while (!bus.ready_o && g < 20) begin
            tick();
            g++;
        end
        tick();
        bus.valid_i = 0;
        lat = 0;
        while (!bus.valid_o && lat < 20) begin
            tick();
            lat++;
        end
        if (!bus.valid_o) check("valid_o_timeout", 0, 1);
        d = int'($signed(bus.data_o));
        c = int'(bus.ch_o);
        repeat (stall) tick();
        bus.ready_i = 1;
        tick();
    endtask

    function automatic longint term(int c, int v);
        longint p = longint'(c) * longint'(v);
`ifdef FIR_SEQ_ROUND_EN
        p += 65536;
`endif
        return p >>> 17;
    endfunction

    function automatic int sat(longint v);
        return v > 131071 ? 131071 : v < -131072 ? -131072 : int'(v);
    endfunction

    function automatic void m_reset();
        m_b0 = 131071;
        m_b1 = -131072;
        m_a1 = 0;
        for (int i = 0; i < 4; i++) begin
            m_xh[i] = 0;
            m_yh[i] = 0;
        end
    endfunction

    function automatic int model(int ch, int x);
        int xs = x * 4;
        int acc;
        acc = sat(term(m_b0, xs));
        acc = sat(longint'(acc) + term(m_b1, m_xh[ch]));
        acc = sat(longint'(acc) + term(m_a1, -m_yh[ch]));
        m_xh[ch] = xs;
        m_yh[ch] = acc;
`ifdef FIR_SEQ_ROUND_EN
        return ((acc + 2) >>> 2) > 32767 ? 32767 : (acc + 2) >>> 2;
`else
        return acc >>> 2;
`endif
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, c, lat, e, a, v;
        bus.valid_i = 0;
        bus.ready_i = 1;
        bus.coef_we_i = 0;
        bus.coef_addr_i = 0;
        bus.coef_data_i = 0;
        bus.data_i = 0;
        bus.ch_i = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        check("rst_ready_o", int'(bus.ready_o), 1);
        check("rst_valid_o", int'(bus.valid_o), 0);
        check("rst_data_o", int'(bus.data_o), 0);
        check("rst_ch_o", int'(bus.ch_o), 0);

        vecs[0] = '{1, 1, 65536, 65536, 0, 0, 16384, 8192};
        vecs[1] = '{0, 0, 0, 0, 0, 0, 16384, 16384};
        vecs[2] = '{1, 1, 131071, 131071, -131072, 1, 32767, 32766};
        vecs[3] = '{0, 0, 0, 0, 0, 1, 32767, 32767};
        vecs[4] = '{1, 1, 65536, 65536, 0, 0, 16384, 8192};
        vecs[5] = '{0, 0, 0, 0, 0, 2, 0, 0};
        vecs[6] = '{0, 0, 0, 0, 0, 0, 0, 8192};
        vecs[7] = '{1, 1, 65536, 65536, 0, 3, -16384, -8192};
        vecs[8] = '{1, 0, 0, 0, 0, 1, 100, 99};
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].rst) do_reset();
            if (vecs[i].wr) begin
                wcoef(0, vecs[i].b0);
                wcoef(1, vecs[i].b1);
                wcoef(2, vecs[i].a1);
            end
            send(vecs[i].ch, vecs[i].x, i % 3, d, c, lat);
            check($sformatf("vec%0d_data", i), d, vecs[i].exp_d);
            check($sformatf("vec%0d_ch", i), c, vecs[i].ch);
            check($sformatf("vec%0d_latency", i), lat, 3);
        end

        // backpressure: output held 10 cycles while the next sample waits
        do_reset();
        set_lin();
        bus.ch_i = 1;
        bus.data_i = 16384;
        bus.valid_i = 1;
        bus.ready_i = 0;
        tick();
        lat = 0;
        while (!bus.valid_o && lat < 20) begin
            tick();
            lat++;
        end
        check("bp_latency", lat, 3);
        repeat (10) begin
            check("bp_valid_o", int'(bus.valid_o), 1);
            check("bp_ready_o", int'(bus.ready_o), 0);
            check("bp_data_o", int'($signed(bus.data_o)), 8192);
            check("bp_ch_o", int'(bus.ch_o), 1);
            tick();
        end
        bus.ready_i = 1;
        tick();
        check("bp_idle_ready_o", int'(bus.ready_o), 1);
        check("bp_idle_valid_o", int'(bus.valid_o), 0);
        tick();
        check("bp_accepted", int'(bus.ready_o), 0);
        bus.valid_i = 0;
        lat = 0;
        while (!bus.valid_o && lat < 20) begin
            tick();
            lat++;
        end
        check("bp_second_data", int'($signed(bus.data_o)), 16384);
        tick();

        // b0 rewritten while the current sample is in MAC_B1
        do_reset();
        set_lin();
        bus.ch_i = 0;
        bus.data_i = 16384;
        bus.valid_i = 1;
        tick();
        bus.valid_i = 0;
        tick();
        bus.coef_we_i = 1;
        bus.coef_addr_i = 0;
        bus.coef_data_i = 0;
        tick();
        bus.coef_we_i = 0;
        tick();
        check("cw_valid_o", int'(bus.valid_o), 1);
        check("cw_old_b0_data", int'($signed(bus.data_o)), 8192);
        tick();
        send(0, 16384, 0, d, c, lat);
        check("cw_new_b0_data", d, 8192);

        // reset while in MAC_A1 drops the sample and leaves history clear
        do_reset();
        set_lin();
        bus.ch_i = 0;
        bus.data_i = 16384;
        bus.valid_i = 1;
        tick();
        bus.valid_i = 0;
        tick();
        tick();
        rst = 1;
        tick();
        rst = 0;
        check("ra1_valid_o", int'(bus.valid_o), 0);
        check("ra1_ready_o", int'(bus.ready_o), 1);
        check("ra1_data_o", int'(bus.data_o), 0);
        set_lin();
        send(0, 16384, 0, d, c, lat);
        check("ra1_next_data", d, 8192);

        do_reset();
        m_reset();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = int'($urandom_range(0, 3));
                v = int'($urandom_range(0, 262143)) - 131072;
                wcoef(a, v);
                if (a == 0) m_b0 = v;
                if (a == 1) m_b1 = v;
                if (a == 2) m_a1 = v;
            end
            c = int'($urandom_range(0, 3));
            v = int'($urandom_range(0, 65535)) - 32768;
            e = model(c, v);
            send(c, v, int'($urandom_range(0, 2)), d, a, lat);
            check($sformatf("rnd%0d_data", i), d, e);
            check($sformatf("rnd%0d_ch", i), a, c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
